ldm_stm_sequencer: RTL and testbench
====================================

LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 SHALL have ports clk (in, 1): the single clock, all state on its rising edge; one clock; reset is asynchronous and active-high.
REQ-002 SHALL have reset (in, 1): asynchronous, active-high.
REQ-003 SHALL have start (in, 1): issue pulse for a Load/Store Multiple instruction (decode family f[13]).
REQ-004 SHALL have ir (in, 32): instruction word, sampled with start.
REQ-005 SHALL have base (in, 32): Rn value, sampled with start.
REQ-006 SHALL have mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_ack (in, 1): word memory handshake.
REQ-007 SHALL have reg_num (out, 4): register being transferred, and reg_wr (out, 1): register-file write strobe for loads.
REQ-008 SHALL have wb_en (out, 1) and wb_value (out, 32): base writeback to Rn.
REQ-009 SHALL have busy (out, 1) and done (out, 1): done is a one-cycle completion pulse.

Function
REQ-010 SHALL decode ir[24]=P, ir[23]=U, ir[21]=W, ir[20]=L, ir[19:16]=Rn, ir[15:0]=list; ir[22] is ignored.
REQ-011 SHALL implement states IDLE, CALC, XFER, WB, DONE; busy=1 in every state except IDLE.
REQ-012 IDLE: start=1 latches ir and base and moves to CALC; start while busy is ignored.
REQ-013 CALC (1 cycle): N=popcount(list); start address IA=base, IB=base+4, DA=base-4N+4, DB=base-4N; N=0 -> DONE, else -> XFER.
REQ-014 XFER: mem_req=1, mem_we=~L, mem_addr={addr[31:2],2'b00}, reg_num=lowest set bit of the pending list; all stay stable until mem_ack.
REQ-015 On mem_req & mem_ack: clear the pending bit, addr+=4, reg_wr=L in that same cycle (combinational); on the last bit go to WB if W=1, else DONE.
REQ-016 Transfers SHALL proceed from the lowest-numbered register at the lowest address, in ascending address order.
REQ-017 Address arithmetic SHALL be modulo 2^32 and wrap silently.
REQ-018 WB: wb_en=1 for one cycle with wb_value = base+4N (U=1) or base-4N (U=0), then DONE; wb_en is suppressed when L=1 and Rn is in the list.
REQ-019 DONE: done=1 for one cycle, then IDLE; start may be accepted in the following cycle.
REQ-020 Latency: start sampled at edge E0 gives CALC after E0 and the first mem_req after E1; an empty list gives done after E1 with no mem_req and no wb_en.
REQ-021 mem_ack outside XFER SHALL be ignored.

Reset
REQ-022 reset SHALL force IDLE immediately and drive mem_req, mem_we, reg_wr, wb_en, busy, done to 0 and mem_addr, reg_num, wb_value to 0.
REQ-023 reset mid-XFER SHALL abandon the transfer with no further strobes; the next start SHALL behave normally.

Structure
REQ-024 The shared package SHALL hold the state encoding, the P/U/W/L/Rn bit-position constants, and the addressing-mode constants IA/IB/DA/DB.
REQ-025 The lowest-set-bit encoder SHALL be a sub-module reg_list_prienc (16-bit in, 4-bit index, valid out); popcount stays inline.

Verification
REQ-026 LDMIA, base=0x1000, list=0x000B, W=1, mem_ack immediate -> addrs 0x1000/0x1004/0x1008, reg_num 0/1/3 each with reg_wr, wb_value=0x100C, then done.
REQ-027 STMDB, base=0x2000, list=0x4010, W=1 -> mem_we=1, r4@0x1FF8 then r14@0x1FFC, wb_value=0x1FF8.
REQ-028 mem_ack delayed 3 cycles on the first beat -> mem_req high 4 cycles with mem_addr and reg_num unchanged, and no reg_wr before ack.
REQ-029 list=0x0000 -> no mem_req, done two cycles after start, no wb_en; a start asserted while busy is ignored.
REQ-030 reset asserted during the second XFER beat -> all outputs 0 immediately; a new LDMIA afterwards completes correctly.
REQ-031 LDMIB, base=0xFFFFFFF8, list=0x0003 -> addrs 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared definitions for the load/store-multiple sequencer: FSM states,
// instruction field positions and addressing modes.
package ldm_stm_sequencer_pkg;

  localparam int unsigned LIST_W    = 16;
  localparam int unsigned IR_P      = 24;
  localparam int unsigned IR_U      = 23;
  localparam int unsigned IR_W      = 21;
  localparam int unsigned IR_L      = 20;
  localparam int unsigned IR_RN_MSB = 19;
  localparam int unsigned IR_RN_LSB = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_XFER = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Encoded as {P,U}.
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } amode_t;

  // Lowest transfer address; span is 4*N.  All arithmetic wraps mod 2^32.
  function automatic logic [31:0] start_addr(input amode_t mode,
                                             input logic [31:0] base,
                                             input logic [31:0] span);
    case (mode)
      MODE_IA: start_addr = base;
      MODE_IB: start_addr = base + 32'd4;
      MODE_DA: start_addr = base - span + 32'd4;
      default: start_addr = base - span;
    endcase
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_prienc.sv
// Lowest-set-bit encoder for the pending register list; purely combinational.
module reg_list_prienc
  import ldm_stm_sequencer_pkg::*;
(
  input  logic [LIST_W-1:0] i_list,
  output logic [3:0]        o_idx,
  output logic              o_vld
);

  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    // Scan downward so the last hit written is the lowest index.
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (i_list[i]) begin
        o_idx = 4'(i);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Load/Store Multiple sequencer: first mem_req two cycles after start, one word per
// mem_ack; each beat holds address and register stable until acknowledged.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic [31:0] base,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  output logic [3:0]  reg_num,
  output logic        reg_wr,
  output logic        wb_en,
  output logic [31:0] wb_value,
  output logic        busy,
  output logic        done
);

  state_t             r_state;
  logic               r_p;
  logic               r_u;
  logic               r_w;
  logic               r_l;
  logic [3:0]         r_rn;
  logic [LIST_W-1:0]  r_list;
  logic [LIST_W-1:0]  r_pending;
  logic [31:0]        r_base;
  logic [31:0]        r_addr;
  logic [31:0]        r_wb_value;
  logic               r_wb_allow;
  logic               r_mem_req;
  logic               r_mem_we;
  logic               r_wb_en;
  logic               r_busy;
  logic               r_done;

  logic [3:0]         w_idx;
  logic               w_idx_vld;
  logic [4:0]         w_count;
  logic [31:0]        w_span;
  logic [31:0]        w_start_addr;
  logic [LIST_W-1:0]  w_pending_next;
  logic               w_ack;
  amode_t             w_mode;
  logic               w_unused_ir;

  assign w_unused_ir = ^{ir[31:25], ir[22]};

  reg_list_prienc u_prienc (
    .i_list (r_pending),
    .o_idx  (w_idx),
    .o_vld  (w_idx_vld)
  );

  always_comb begin
    w_count = '0;
    for (int i = 0; i < LIST_W; i++) begin
      w_count = w_count + 5'(r_list[i]);
    end
  end

  assign w_span         = {25'd0, w_count, 2'b00};
  assign w_mode         = amode_t'({r_p, r_u});
  assign w_start_addr   = start_addr(w_mode, r_base, w_span);
  assign w_pending_next = r_pending & ~(16'd1 << w_idx);
  assign w_ack          = r_mem_req & mem_ack & w_idx_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_p        <= 1'b0;
      r_u        <= 1'b0;
      r_w        <= 1'b0;
      r_l        <= 1'b0;
      r_rn       <= '0;
      r_list     <= '0;
      r_pending  <= '0;
      r_base     <= '0;
      r_addr     <= '0;
      r_wb_value <= '0;
      r_wb_allow <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_wb_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_p     <= ir[IR_P];
            r_u     <= ir[IR_U];
            r_w     <= ir[IR_W];
            r_l     <= ir[IR_L];
            r_rn    <= ir[IR_RN_MSB:IR_RN_LSB];
            r_list  <= ir[LIST_W-1:0];
            r_base  <= base;
            r_busy  <= 1'b1;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_pending  <= r_list;
          r_addr     <= w_start_addr;
          r_wb_value <= r_u ? (r_base + w_span) : (r_base - w_span);
          // A load that reloads the base register wins over the writeback.
          r_wb_allow <= r_w & ~(r_l & r_list[r_rn]);
          if (w_count == 5'd0) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_mem_req <= 1'b1;
            r_mem_we  <= ~r_l;
            r_state   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_ack) begin
            r_pending <= w_pending_next;
            r_addr    <= r_addr + 32'd4;
            if (w_pending_next == '0) begin
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              if (r_w) begin
                r_wb_en <= r_wb_allow;
                r_state <= ST_WB;
              end else begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            end
          end
        end
        ST_WB: begin
          r_wb_en <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_wb_en   <= 1'b0;
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign reg_num  = r_mem_req ? w_idx : 4'd0;
  assign reg_wr   = w_ack & r_l;
  assign wb_en    = r_wb_en;
  assign wb_value = r_wb_value;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: expected beats and writebacks are queued
// at issue time and retired by a negedge monitor.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] base = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, reg_wr, wb_en, busy, done;
  logic [31:0] mem_addr, wb_value;
  logic [3:0]  reg_num;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  rn;
    logic        rw;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] wb_q[$];
  int          ack_q[$];
  beat_t       mon_e;
  logic [31:0] mon_wb;
  bit          mon_en = 1'b0;
  bit          ack_spurious = 1'b0;
  bit          have_delay = 1'b0;
  int          cur_delay = 0;
  int          beat_wait = 0;

  ldm_stm_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ir       (ir),
    .base     (base),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .reg_num  (reg_num),
    .reg_wr   (reg_wr),
    .wb_en    (wb_en),
    .wb_value (wb_value),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_ir(input bit p, input bit u, input bit w, input bit l,
                                        input logic [3:0] rn, input logic [15:0] list);
    mk_ir = {4'hE, 3'b100, p, u, 1'b0, w, l, rn, list};
  endfunction

  function automatic beat_t mk_beat(input logic we, input logic [31:0] addr,
                                    input logic [3:0] rn, input logic rw);
    mk_beat.we = we; mk_beat.addr = addr; mk_beat.rn = rn; mk_beat.rw = rw;
  endfunction

  // Memory model: each beat takes its ack delay from ack_q (0 when empty).
  always @(posedge clk) begin
    #1;
    if (reset || !mem_req) begin
      mem_ack = ack_spurious;
      have_delay = 1'b0;
      beat_wait = 0;
    end else begin
      if (mem_ack && have_delay) begin
        have_delay = 1'b0;
      end
      if (!have_delay) begin
        cur_delay = (ack_q.size() > 0) ? ack_q.pop_front() : 0;
        have_delay = 1'b1;
        beat_wait = 0;
      end
      mem_ack = (beat_wait >= cur_delay);
      beat_wait++;
    end
  end

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (mem_req && mem_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got addr=%h reg=%0d we=%b, required no beat", mem_addr, reg_num, mem_we);
        end else begin
          mon_e = exp_q.pop_front();
          if ({mem_we, mem_addr, reg_num, reg_wr} !== {mon_e.we, mon_e.addr, mon_e.rn, mon_e.rw}) begin
            errors++;
            $display("FAIL beat: got we=%b addr=%h reg=%0d wr=%b, required we=%b addr=%h reg=%0d wr=%b",
                     mem_we, mem_addr, reg_num, reg_wr, mon_e.we, mon_e.addr, mon_e.rn, mon_e.rw);
          end
        end
      end else begin
        checks++;
        if (reg_wr !== 1'b0) begin
          errors++;
          $display("FAIL reg_wr_without_ack: got %b, required 0", reg_wr);
        end
      end
      if (wb_en) begin
        checks++;
        if (wb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wb: got wb_value=%h, required wb_en=0", wb_value);
        end else begin
          mon_wb = wb_q.pop_front();
          if (wb_value !== mon_wb) begin
            errors++;
            $display("FAIL wb_value: got %h, required %h", wb_value, mon_wb);
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] i, input logic [31:0] b);
    @(posedge clk); #2;
    start = 1'b1; ir = i; base = b;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, reg_wr, wb_en, busy, done} !== 6'b0 || mem_addr !== 32'd0 ||
        reg_num !== 4'd0 || wb_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b wr=%b wb=%b busy=%b done=%b addr=%h reg=%0d wbv=%h, required all 0",
               mem_req, mem_we, reg_wr, wb_en, busy, done, mem_addr, reg_num, wb_value);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b, required 0", busy);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_ldmia;
    int c;
    exp_q.push_back(mk_beat(1'b0, 32'h1000, 4'd0, 1'b1));
    exp_q.push_back(mk_beat(1'b0, 32'h1004, 4'd1, 1'b1));
    exp_q.push_back(mk_beat(1'b0, 32'h1008, 4'd3, 1'b1));
    wb_q.push_back(32'h100C);
    issue(mk_ir(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 16'h000B), 32'h1000);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ldmia_calc_cycle: got req=%b busy=%b, required req=0 busy=1", mem_req, busy);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h1000) begin
      errors++;
      $display("FAIL ldmia_first_req: got req=%b addr=%h, required req=1 addr=00001000", mem_req, mem_addr);
    end
    c = 0;
    while (!done && c < 100) begin @(negedge clk); c++; end
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0 || wb_q.size() != 0) begin
      errors++;
      $display("FAIL ldmia_done: got done=%b beats_left=%0d wb_left=%0d, required done=1 and 0 left", done, exp_q.size(), wb_q.size());
    end
  endtask

  task automatic test_stmdb;
    int c;
    exp_q.push_back(mk_beat(1'b1, 32'h1FF8, 4'd4, 1'b0));
    exp_q.push_back(mk_beat(1'b1, 32'h1FFC, 4'd14, 1'b0));
    wb_q.push_back(32'h1FF8);
    issue(mk_ir(1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 16'h4010), 32'h2000);
    c = 0;
    while (!done && c < 100) begin @(negedge clk); c++; end
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0 || wb_q.size() != 0) begin
      errors++;
      $display("FAIL stmdb_done: got done=%b beats_left=%0d wb_left=%0d, required done=1 and 0 left", done, exp_q.size(), wb_q.size());
    end
  endtask

  task automatic test_ack_delay;
    int c, high;
    bit got, stable;
    logic [31:0] a0;
    logic [3:0]  r0;
    ack_q.push_back(3);
    exp_q.push_back(mk_beat(1'b0, 32'h3000, 4'd1, 1'b1));
    exp_q.push_back(mk_beat(1'b0, 32'h3004, 4'd2, 1'b1));
    issue(mk_ir(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0006), 32'h3000);
    high = 0; got = 1'b0; stable = 1'b1; a0 = '0; r0 = '0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (mem_req) begin
        if (high == 0) begin a0 = mem_addr; r0 = reg_num; end
        else if (mem_addr !== a0 || reg_num !== r0) stable = 1'b0;
        high++;
        if (mem_ack) got = 1'b1;
      end
    end
    checks++;
    if (high != 4) begin
      errors++;
      $display("FAIL ack_delay_req_cycles: got %0d, required 4", high);
    end
    checks++;
    if (!stable || a0 !== 32'h3000 || r0 !== 4'd1) begin
      errors++;
      $display("FAIL ack_delay_stable: got stable=%b addr=%h reg=%0d, required stable=1 addr=00003000 reg=1", stable, a0, r0);
    end
    c = 0;
    while (!done && c < 100) begin @(negedge clk); c++; end
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ack_delay_done: got done=%b beats_left=%0d, required done=1 and 0 left", done, exp_q.size());
    end
  endtask

  task automatic test_empty_and_busy_start;
    ack_spurious = 1'b1;
    issue(mk_ir(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 16'h0000), 32'h7000);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL empty_calc: got busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    start = 1'b1;
    ir = mk_ir(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 16'h00FF);
    base = 32'h8000;
    @(posedge clk); #2;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || mem_req !== 1'b0 || wb_en !== 1'b0) begin
      errors++;
      $display("FAIL empty_done_timing: got done=%b req=%b wb=%b, required done=1 req=0 wb=0", done, mem_req, wb_en);
    end
    @(posedge clk); #2;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_done_pulse: got done=%b busy=%b, required done=0 busy=0", done, busy);
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: got busy=%b req=%b, required busy=0 req=0", busy, mem_req);
    end
    ack_spurious = 1'b0;
  endtask

  task automatic test_reset_mid_xfer;
    int c;
    bit got;
    ack_q.push_back(0);
    ack_q.push_back(5);
    exp_q.push_back(mk_beat(1'b0, 32'h4000, 4'd4, 1'b1));
    issue(mk_ir(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 16'h00F0), 32'h4000);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (mem_req && mem_ack) got = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || reg_num !== 4'd5 || mem_addr !== 32'h4004) begin
      errors++;
      $display("FAIL second_beat: got req=%b reg=%0d addr=%h, required req=1 reg=5 addr=00004004", mem_req, reg_num, mem_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, reg_wr, wb_en, busy, done} !== 6'b0 || mem_addr !== 32'd0 ||
        reg_num !== 4'd0 || wb_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_xfer: got req=%b we=%b wr=%b wb=%b busy=%b done=%b addr=%h reg=%0d, required all 0",
               mem_req, mem_we, reg_wr, wb_en, busy, done, mem_addr, reg_num);
    end
    ack_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_first_beat_missing: got %0d left, required 0", exp_q.size());
    end
    exp_q.delete();
    exp_q.push_back(mk_beat(1'b0, 32'h5000, 4'd0, 1'b1));
    exp_q.push_back(mk_beat(1'b0, 32'h5004, 4'd5, 1'b1));
    wb_q.push_back(32'h5008);
    issue(mk_ir(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 16'h0021), 32'h5000);
    c = 0;
    while (!done && c < 100) begin @(negedge clk); c++; end
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0 || wb_q.size() != 0) begin
      errors++;
      $display("FAIL after_reset_done: got done=%b beats_left=%0d wb_left=%0d, required done=1 and 0 left", done, exp_q.size(), wb_q.size());
    end
  endtask

  task automatic test_ldmib_wrap;
    int c;
    exp_q.push_back(mk_beat(1'b0, 32'hFFFF_FFFC, 4'd0, 1'b1));
    exp_q.push_back(mk_beat(1'b0, 32'h0000_0000, 4'd1, 1'b1));
    wb_q.push_back(32'h0000_0000);
    issue(mk_ir(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 16'h0003), 32'hFFFF_FFF8);
    c = 0;
    while (!done && c < 100) begin @(negedge clk); c++; end
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0 || wb_q.size() != 0) begin
      errors++;
      $display("FAIL ldmib_wrap_done: got done=%b beats_left=%0d wb_left=%0d, required done=1 and 0 left", done, exp_q.size(), wb_q.size());
    end
  endtask

  task automatic test_wb_suppress;
    int c;
    exp_q.push_back(mk_beat(1'b0, 32'h5FFC, 4'd3, 1'b1));
    exp_q.push_back(mk_beat(1'b0, 32'h6000, 4'd4, 1'b1));
    issue(mk_ir(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 16'h0018), 32'h6000);
    c = 0;
    while (!done && c < 100) begin @(negedge clk); c++; end
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wb_suppress_done: got done=%b beats_left=%0d, required done=1 and 0 left", done, exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    int c, n;
    bit p, u, w, l;
    logic [3:0]  rn;
    logic [15:0] list;
    logic [31:0] b, a;
    for (int t = 0; t < 8; t++) begin
      {p, u, w, l} = 4'($urandom_range(0, 15));
      rn   = 4'($urandom_range(0, 15));
      list = 16'($urandom);
      if (t == 3) list = 16'h8001;
      b    = $urandom;
      n    = $countones(list);
      case ({p, u})
        2'b01:   a = b;
        2'b11:   a = b + 32'd4;
        2'b00:   a = b - 32'(4 * n) + 32'd4;
        default: a = b - 32'(4 * n);
      endcase
      for (int r = 0; r < 16; r++) begin
        if (list[r]) begin
          exp_q.push_back(mk_beat(~l, {a[31:2], 2'b00}, 4'(r), l));
          ack_q.push_back($urandom_range(0, 2));
          a = a + 32'd4;
        end
      end
      if (n != 0 && w && !(l && list[rn]))
        wb_q.push_back(u ? b + 32'(4 * n) : b - 32'(4 * n));
      issue(mk_ir(p, u, w, l, rn, list), b);
      c = 0;
      while (!done && c < 200) begin @(negedge clk); c++; end
      checks++;
      if (done !== 1'b1 || exp_q.size() != 0 || wb_q.size() != 0) begin
        errors++;
        $display("FAIL b2b_%0d_done: got done=%b beats_left=%0d wb_left=%0d, required done=1 and 0 left", t, done, exp_q.size(), wb_q.size());
      end
      exp_q.delete();
      wb_q.delete();
      ack_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_ldmia();
    test_stmdb();
    test_ack_delay();
    test_empty_and_busy_start();
    test_reset_mid_xfer();
    test_ldmib_wrap();
    test_wb_suppress();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
